// File: rtl/loop_buffer_pkg.sv
// Shared opcode constants, controller state type and the backward-branch detector
// used by the loop-stream controller.
package loop_buffer_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        REPLAY,
        EXIT
    } lb_state_e;

    function automatic logic is_ctrl_opcode(input logic [31:0] insn);
        return (insn[6:0] == OPC_BRANCH) || (insn[6:0] == OPC_JAL);
    endfunction

    // imm arrives sign-extended to 64 bits so one function serves any XLEN up to 64.
    function automatic logic is_backward_ctrl(input logic [31:0] insn,
                                              input logic [63:0] imm,
                                              input int unsigned depth);
        logic [63:0] words;
        words = (~imm + 64'd1) >> 2;
        return is_ctrl_opcode(insn) && imm[63] &&
               (words != 64'd0) && (words < 64'(depth));
    endfunction

endpackage

// File: rtl/loop_buffer_ram.sv
// Loop body storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; only entries written during capture are ever read.
module loop_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/loop_buffer_ctrl.sv
// Loop-stream controller: confirms a short backward branch, captures its body and
// replays it to decode while fetch is stalled, until a mispredict redirects fetch.
//   state   | meaning
//   IDLE    | watching for a backward branch/JAL candidate
//   ARM     | counting repeat sightings of the latched branch PC
//   CAPTURE | waiting for the loop target, then recording the body contiguously
//   REPLAY  | fetch stalled, stored body streamed out over valid/ready
//   EXIT    | one-cycle flush with redirect to the loop fall-through
module loop_buffer_ctrl
    import loop_buffer_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CONF_THRESH = 2,
    parameter int ITER_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_insn,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              mispredict,
    input  logic              replay_ready,
    output logic              replay_valid,
    output logic [XLEN-1:0]   replay_pc,
    output logic [31:0]       replay_insn,
    output logic              fetch_stall,
    output logic              flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              loop_active,
    output logic [ITER_W-1:0] loop_iters
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CONF_W = 4;

    lb_state_e         r_state, w_state_nxt;
    logic [XLEN-1:0]   r_br_pc, r_target, r_redirect_pc;
    logic [IDX_W-1:0]  r_last_idx, r_wr_ptr, r_rd_ptr;
    logic [CONF_W-1:0] r_conf;
    logic              r_filling;
    logic [ITER_W-1:0] r_iters;

    logic [63:0]       w_imm64;
    logic [IDX_W-1:0]  w_last_idx;
    logic [XLEN-1:0]   w_exp_pc;
    logic              w_cand, w_is_br_pc, w_fill_hit, w_pc_bad, w_stray;
    logic              w_full, w_cap_abort, w_cap_done, w_we, w_hs, w_wrap;
    logic [XLEN+31:0]  w_rdata;

    assign w_imm64    = 64'($signed(in_imm));
    assign w_cand     = in_valid && is_backward_ctrl(in_insn, w_imm64, DEPTH);
    assign w_last_idx = IDX_W'((-in_imm) >> 2);
    assign w_is_br_pc = (in_pc == r_br_pc);
    assign w_exp_pc   = r_target + (XLEN'(r_wr_ptr) << 2);

    // Recording starts at the target and must then stay strictly sequential.
    assign w_fill_hit  = in_valid && (r_filling || (in_pc == r_target));
    assign w_pc_bad    = r_filling && (in_pc != w_exp_pc);
    assign w_stray     = is_ctrl_opcode(in_insn) && !w_is_br_pc;
    assign w_full      = &r_wr_ptr;
    assign w_cap_abort = mispredict ||
                         (w_fill_hit && (w_pc_bad || w_stray || (w_full && !w_is_br_pc)));
    assign w_cap_done  = w_fill_hit && !w_cap_abort && w_is_br_pc;
    assign w_we        = (r_state == CAPTURE) && w_fill_hit && !w_cap_abort;

    assign w_hs   = (r_state == REPLAY) && replay_ready;
    assign w_wrap = (r_rd_ptr == r_last_idx);

    loop_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + 32)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_pc, in_insn}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cand) w_state_nxt = (CONF_THRESH == 1) ? CAPTURE : ARM;
            end
            ARM: begin
                if (mispredict)
                    w_state_nxt = IDLE;
                else if (w_cand && w_is_br_pc && (r_conf == CONF_W'(CONF_THRESH - 1)))
                    w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (w_cap_abort)     w_state_nxt = IDLE;
                else if (w_cap_done) w_state_nxt = REPLAY;
            end
            REPLAY: begin
                if (mispredict) w_state_nxt = EXIT;
            end
            EXIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_br_pc       <= '0;
            r_target      <= '0;
            r_redirect_pc <= '0;
            r_last_idx    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_conf        <= '0;
            r_filling     <= 1'b0;
            r_iters       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE, ARM: begin
                    r_wr_ptr  <= '0;
                    r_filling <= 1'b0;
                    if (w_cand && !((r_state == ARM) && mispredict)) begin
                        if ((r_state == ARM) && w_is_br_pc) begin
                            r_conf <= r_conf + CONF_W'(1);
                        end else begin
                            r_br_pc    <= in_pc;
                            r_target   <= in_pc + in_imm;
                            r_last_idx <= w_last_idx;
                            r_conf     <= CONF_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (w_we) begin
                        r_wr_ptr  <= r_wr_ptr + IDX_W'(1);
                        r_filling <= 1'b1;
                    end
                    if (w_cap_done) begin
                        r_rd_ptr <= '0;
                        r_iters  <= '0;
                    end
                end
                REPLAY: begin
                    // A handshake coinciding with the mispredict still retires.
                    if (w_hs) begin
                        r_rd_ptr <= w_wrap ? '0 : r_rd_ptr + IDX_W'(1);
                        if (w_wrap && (r_iters != '1)) r_iters <= r_iters + ITER_W'(1);
                    end
                    if (mispredict) r_redirect_pc <= r_br_pc + XLEN'(4);
                end
                default: ;
            endcase
        end
    end

    assign replay_valid = (r_state == REPLAY);
    assign fetch_stall  = (r_state == REPLAY);
    assign loop_active  = (r_state == REPLAY);
    assign flush        = (r_state == EXIT);
    assign redirect_pc  = r_redirect_pc;
    assign loop_iters   = r_iters;
    assign replay_pc    = replay_valid ? w_rdata[XLEN+31:32] : '0;
    assign replay_insn  = replay_valid ? w_rdata[31:0] : '0;

endmodule

// File: tb/tb_loop_buffer_ctrl.sv
// Bench for loop_buffer_ctrl: directed scenarios against hand-derived constants, then
// randomized loops checked cycle by cycle against a queue-based behavioural model.
module tb_loop_buffer_ctrl;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 16;
    localparam int THRESH   = 2;
    localparam int ITER_W   = 4;
    localparam int ITER_MAX = (1 << ITER_W) - 1;

    localparam logic [31:0] BNE_I = 32'hFE0098E3;
    localparam logic [31:0] BEQ_I = 32'h00008463;
    localparam logic [31:0] JAL_I = 32'hFF5FF06F;

    logic              clk = 1'b0;
    logic              reset, in_valid, mispredict, replay_ready;
    logic [XLEN-1:0]   in_pc, in_imm;
    logic [31:0]       in_insn;
    logic              replay_valid, fetch_stall, flush, loop_active;
    logic [XLEN-1:0]   replay_pc, redirect_pc;
    logic [31:0]       replay_insn;
    logic [ITER_W-1:0] loop_iters;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    loop_buffer_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CONF_THRESH(THRESH), .ITER_W(ITER_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_insn(in_insn), .in_imm(in_imm), .mispredict(mispredict),
        .replay_ready(replay_ready), .replay_valid(replay_valid),
        .replay_pc(replay_pc), .replay_insn(replay_insn), .fetch_stall(fetch_stall),
        .flush(flush), .redirect_pc(redirect_pc), .loop_active(loop_active),
        .loop_iters(loop_iters)
    );

    // ---------------- behavioural model: 0 idle, 1 arm, 2 capture, 3 replay, 4 exit
    int          m_st = 0, m_conf = 0, m_rd = 0, m_iters = 0, m_w = 0;
    logic [31:0] m_br = 0, m_tgt = 0, m_redirect = 0, m_want;
    bit          m_ctrl;
    logic [63:0] m_body[$];

    function automatic int words_back(input logic [31:0] insn, input logic [31:0] imm);
        longint s = longint'($signed(imm));
        int w;
        if (!(insn[6:0] == 7'h63 || insn[6:0] == 7'h6F) || s >= 0) return 0;
        w = int'((-s) / 4);
        return (w >= 1 && w <= DEPTH - 1) ? w : 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0; m_conf = 0; m_rd = 0; m_iters = 0; m_redirect = 0;
            m_body.delete();
        end else begin
            case (m_st)
                0, 1: begin
                    m_w = in_valid ? words_back(in_insn, in_imm) : 0;
                    if (m_st == 1 && mispredict) m_st = 0;
                    else if (m_w != 0) begin
                        if (m_st == 1 && in_pc == m_br) m_conf++;
                        else begin m_br = in_pc; m_tgt = in_pc + in_imm; m_conf = 1; end
                        m_st = (m_conf >= THRESH) ? 2 : 1;
                        m_body.delete();
                    end
                end
                2: begin
                    if (mispredict) m_st = 0;
                    else if (in_valid && (m_body.size() > 0 || in_pc == m_tgt)) begin
                        m_want = m_tgt + 32'(4 * m_body.size());
                        m_ctrl = (in_insn[6:0] == 7'h63) || (in_insn[6:0] == 7'h6F);
                        if (m_body.size() > 0 && in_pc != m_want) m_st = 0;
                        else if (m_ctrl && in_pc != m_br) m_st = 0;
                        else begin
                            m_body.push_back({in_pc, in_insn});
                            if (in_pc == m_br) begin m_st = 3; m_rd = 0; m_iters = 0; end
                            else if (m_body.size() == DEPTH) m_st = 0;
                        end
                    end
                end
                3: begin
                    if (replay_ready) begin
                        m_rd++;
                        if (m_rd == m_body.size()) begin
                            m_rd = 0;
                            if (m_iters < ITER_MAX) m_iters++;
                        end
                    end
                    if (mispredict) begin m_st = 4; m_redirect = m_br + 32'd4; end
                end
                default: m_st = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic feed(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic [31:0] imm);
        in_valid = v; in_pc = pc; in_insn = insn; in_imm = imm;
        tick();
    endtask

    function automatic logic [31:0] body_insn(input int k);
        return 32'h0000_0013 | (32'(k) << 20);
    endfunction

    // One pass of a loop of len instructions at base; index stray is replaced by a BEQ.
    task automatic feed_loop(input logic [31:0] base, input int len, input int stray);
        for (int k = 0; k < len; k++) begin
            if (k == len - 1)  feed(1'b1, base + 32'(4 * k), BNE_I, 32'(-(4 * (len - 1))));
            else if (k == stray) feed(1'b1, base + 32'(4 * k), BEQ_I, 32'd8);
            else               feed(1'b1, base + 32'(4 * k), body_insn(k), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; mispredict = 1'b0; replay_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed scenarios
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; mispredict = 1'b0; replay_ready = 1'b0;
        in_pc = '0; in_insn = '0; in_imm = '0;
        tick(); tick();
        n_vec++;
        if ({replay_valid, replay_pc, replay_insn, fetch_stall, flush, redirect_pc,
             loop_active, loop_iters} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b pc=%h insn=%h st=%b fl=%b rd=%h act=%b it=%0d, want all 0",
                     replay_valid, replay_pc, replay_insn, fetch_stall, flush, redirect_pc,
                     loop_active, loop_iters);
        end
        reset = 1'b0;
    endtask

    task automatic test_capture_replay();
        do_reset();
        feed_loop(32'h100, 4, -1);
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (fetch_stall !== 1'b0 || loop_active !== 1'b0) begin
            n_err++;
            $display("FAIL early_replay: got stall=%b active=%b after 2 passes, want 0 0",
                     fetch_stall, loop_active);
        end
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (replay_valid !== 1'b1 || fetch_stall !== 1'b1 || loop_active !== 1'b1 ||
            replay_pc !== 32'h100 || replay_insn !== 32'h13 || loop_iters !== 0) begin
            n_err++;
            $display("FAIL replay_entry: got v=%b st=%b act=%b pc=%h insn=%h it=%0d, want 1 1 1 100 00000013 0",
                     replay_valid, fetch_stall, loop_active, replay_pc, replay_insn, loop_iters);
        end
        replay_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (replay_pc !== 32'h100 + 32'(4 * (k % 4)) || replay_insn !== body_insn(k % 4) &&
                k % 4 != 3) begin
                n_err++;
                $display("FAIL replay_seq[%0d]: got pc=%h insn=%h, want pc=%h", k, replay_pc,
                         replay_insn, 32'h100 + 32'(4 * (k % 4)));
            end
        end
        n_vec++;
        if (loop_iters !== 1) begin
            n_err++;
            $display("FAIL iters_first_wrap: got %0d, want 1", loop_iters);
        end
    endtask

    task automatic test_ready_hold();
        replay_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (replay_pc !== 32'h100 || replay_valid !== 1'b1) begin
                n_err++;
                $display("FAIL ready_hold[%0d]: got pc=%h v=%b, want 100 1", k, replay_pc, replay_valid);
            end
        end
        replay_ready = 1'b1;
        tick();
        n_vec++;
        if (replay_pc !== 32'h104) begin
            n_err++;
            $display("FAIL ready_resume: got pc=%h, want 104", replay_pc);
        end
        tick();
        tick();
        n_vec++;
        if (replay_pc !== 32'h10C || loop_iters !== 1) begin
            n_err++;
            $display("FAIL ready_advance: got pc=%h it=%0d, want 10c 1", replay_pc, loop_iters);
        end
    endtask

    task automatic test_exit();
        mispredict = 1'b1; replay_ready = 1'b1;
        tick();
        mispredict = 1'b0; replay_ready = 1'b0;
        n_vec++;
        if (flush !== 1'b1 || redirect_pc !== 32'h110 || fetch_stall !== 1'b0 ||
            replay_valid !== 1'b0 || loop_active !== 1'b0 || loop_iters !== 2) begin
            n_err++;
            $display("FAIL exit_flush: got fl=%b rd=%h st=%b v=%b act=%b it=%0d, want 1 110 0 0 0 2",
                     flush, redirect_pc, fetch_stall, replay_valid, loop_active, loop_iters);
        end
        tick();
        n_vec++;
        if (flush !== 1'b0 || loop_active !== 1'b0 || redirect_pc !== 32'h110) begin
            n_err++;
            $display("FAIL exit_one_pulse: got fl=%b act=%b rd=%h, want 0 0 110",
                     flush, loop_active, redirect_pc);
        end
        feed_loop(32'h100, 4, -1);
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (loop_active !== 1'b0) begin
            n_err++;
            $display("FAIL exit_to_idle: got active=%b after 2 passes, want 0", loop_active);
        end
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (loop_active !== 1'b1 || replay_pc !== 32'h100) begin
            n_err++;
            $display("FAIL exit_recapture: got active=%b pc=%h, want 1 100", loop_active, replay_pc);
        end
    endtask

    task automatic test_reset_mid_replay();
        replay_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        n_vec++;
        if (loop_iters !== 1 || replay_pc !== 32'h108 || redirect_pc !== 32'h110) begin
            n_err++;
            $display("FAIL pre_reset: got it=%0d pc=%h rd=%h, want 1 108 110",
                     loop_iters, replay_pc, redirect_pc);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; replay_ready = 1'b0;
        n_vec++;
        if ({replay_valid, replay_pc, replay_insn, fetch_stall, flush, redirect_pc,
             loop_active, loop_iters} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_replay: got v=%b pc=%h st=%b fl=%b rd=%h act=%b it=%0d, want all 0",
                     replay_valid, replay_pc, fetch_stall, flush, redirect_pc, loop_active, loop_iters);
        end
        feed_loop(32'h100, 4, -1);
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (loop_active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_conf_cleared: got active=%b, want 0", loop_active);
        end
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (loop_active !== 1'b1) begin
            n_err++;
            $display("FAIL reset_recapture: got active=%b, want 1", loop_active);
        end
    endtask

    task automatic test_inner_branch();
        do_reset();
        feed_loop(32'h100, 4, -1);
        feed_loop(32'h100, 4, -1);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3)      feed(1'b1, 32'h100 + 32'(4 * k), BNE_I, 32'hFFFF_FFF4);
                else if (p == 0 && k == 1) feed(1'b1, 32'h104, BEQ_I, 32'd8);
                else             feed(1'b1, 32'h100 + 32'(4 * k), body_insn(k), 32'd0);
                n_vec++;
                if (fetch_stall !== 1'b0 || flush !== 1'b0) begin
                    n_err++;
                    $display("FAIL inner_branch[%0d.%0d]: got st=%b fl=%b, want 0 0",
                             p, k, fetch_stall, flush);
                end
            end
        end
        in_valid = 1'b0;
        feed_loop(32'h100, 4, -1);
        n_vec++;
        if (loop_active !== 1'b1) begin
            n_err++;
            $display("FAIL inner_branch_recover: got active=%b, want 1", loop_active);
        end
    endtask

    task automatic test_imm_bound();
        do_reset();
        feed(1'b1, 32'h200, BNE_I, 32'(-(4 * DEPTH)));
        feed(1'b1, 32'h200, BNE_I, 32'(-(4 * DEPTH)));
        in_valid = 1'b0;
        for (int p = 0; p < 3; p++) feed_loop(32'h100, 4, -1);
        n_vec++;
        if (loop_active !== 1'b1) begin
            n_err++;
            $display("FAIL imm_depth_rejected: got active=%b, want 1", loop_active);
        end
        do_reset();
        for (int p = 0; p < 3; p++) feed_loop(32'h400, DEPTH, -1);
        n_vec++;
        if (loop_active !== 1'b1 || replay_pc !== 32'h400) begin
            n_err++;
            $display("FAIL imm_max_accepted: got active=%b pc=%h, want 1 400", loop_active, replay_pc);
        end
        replay_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) tick();
        replay_ready = 1'b0;
        n_vec++;
        if (replay_pc !== 32'h400 || loop_iters !== 1) begin
            n_err++;
            $display("FAIL imm_max_wrap: got pc=%h it=%0d, want 400 1", replay_pc, loop_iters);
        end
    endtask

    // ---------------- randomized loops against the model
    task automatic test_random();
        logic [31:0] base, r, e_pc, e_in;
        int len, stray, idx, rep_cycles, rep_limit, k;
        bit done, e_v;
        for (int sc = 0; sc < 30; sc++) begin
            do_reset();
            len   = $urandom_range(2, DEPTH);
            base  = (sc == 3) ? 32'hFFFF_FFF8 : 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
            if (sc == 3) len = 4;
            stray = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 2) : -1;
            rep_limit = $urandom_range(3, 60);
            idx = 0; rep_cycles = 0; done = 0;
            for (int c = 0; c < 400 && !done; c++) begin
                k = idx % len;
                r = $urandom();
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = base + 32'(4 * k);
                if (k == len - 1) begin
                    in_insn = r[0] ? JAL_I : BNE_I;
                    in_imm  = 32'(-(4 * (len - 1)));
                end else if (k == stray) begin
                    in_insn = {r[31:7], 7'h63};
                    in_imm  = 32'd8;
                end else begin
                    in_insn = {r[31:7], 7'h13};
                    in_imm  = 32'(r[19:8]);
                end
                replay_ready = ($urandom_range(0, 3) != 0);
                if (m_st == 3)                  mispredict = (rep_cycles >= rep_limit);
                else if (m_st == 1 || m_st == 2) mispredict = ($urandom_range(0, 60) == 0);
                else                            mispredict = 1'b0;
                tick();
                if (in_valid) idx++;
                if (m_st == 3) rep_cycles++;
                done = (m_st == 4);
                e_v = (m_st == 3);
                e_pc = 32'h0; e_in = 32'h0;
                if (e_v) begin e_pc = m_body[m_rd][63:32]; e_in = m_body[m_rd][31:0]; end
                n_vec++;
                if (replay_valid !== e_v || replay_pc !== e_pc || replay_insn !== e_in ||
                    fetch_stall !== e_v || loop_active !== e_v || flush !== (m_st == 4) ||
                    redirect_pc !== m_redirect || loop_iters !== ITER_W'(m_iters)) begin
                    n_err++;
                    $display("FAIL random sc=%0d cyc=%0d: got v=%b pc=%h insn=%h st=%b act=%b fl=%b rd=%h it=%0d; want v=%b pc=%h insn=%h fl=%b rd=%h it=%0d",
                             sc, c, replay_valid, replay_pc, replay_insn, fetch_stall, loop_active,
                             flush, redirect_pc, loop_iters, e_v, e_pc, e_in, (m_st == 4),
                             m_redirect, m_iters);
                end
            end
            in_valid = 1'b0; mispredict = 1'b0; replay_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_capture_replay();
        test_ready_hold();
        test_exit();
        test_reset_mid_replay();
        test_inner_branch();
        test_imm_bound();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/loop_buffer_ctrl.md
Name: loop_buffer_ctrl

Overview:
Parametrised loop-stream controller between IF/ID and decode.
- Detects a short backward branch/JAL, confirms it over a configurable number of sightings, then captures one full loop body into local storage.
- Stalls fetch and replays the stored body through a valid/ready interface until a mispredict, then flushes and redirects fetch to the loop fall-through.
- Successor to the single-size tracker: adds depth/width parameters, a confidence threshold, PC-contiguity checking, handshaked replay and an iteration counter.

Parameters:
XLEN, 32, PC/immediate width.
DEPTH, 16, loop storage entries (power of 2, ≥4); max loop = DEPTH instructions.
CONF_THRESH, 2, sightings of the same backward branch PC required before capture (1..15).
ITER_W, 16, width of the iteration counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  IF/ID slot holds a valid instruction
in_pc  in  XLEN  PC of the IF/ID instruction
in_insn  in  32  instruction word
in_imm  in  XLEN  sign-extended branch/JAL immediate
mispredict  in  1  resolved branch mispredict from EX
replay_ready  in  1  decode accepts a replayed instruction
replay_valid  out  1  replay slot valid
replay_pc  out  XLEN  PC of the replayed instruction
replay_insn  out  32  replayed instruction word
fetch_stall  out  1  hold the fetch PC (high in REPLAY)
flush  out  1  one-cycle pulse; flush the front end
redirect_pc  out  XLEN  fetch target; valid while flush=1
loop_active  out  1  state is REPLAY
loop_iters  out  ITER_W  completed replay iterations, saturating

Behaviour:
- Candidate: in_valid, opcode 1100011 or 1101111, in_imm[XLEN-1]=1, and (-in_imm)>>2 in 1..DEPTH-1.
  - len = ((-in_imm)>>2)+1 instructions.
  - target = in_pc+in_imm.
- IDLE: on a candidate, latch br_pc, target, len; conf=1.
  - If CONF_THRESH=1, go to CAPTURE; otherwise go to ARM.
- ARM:
  - Candidate with in_pc==br_pc: conf+1. At conf==CONF_THRESH, go to CAPTURE.
  - Candidate with a different PC: relatch it, conf=1, stay in ARM.
  - mispredict: go to IDLE.
- CAPTURE: fill waits for in_pc==target, then writes entry wr_ptr={in_pc,in_insn} and increments wr_ptr on each in_valid.
  - Abort to IDLE (no flush) if any of these occur:
    - in_pc ≠ target+4*wr_ptr once filling has started;
    - a branch/JAL opcode at a PC other than br_pc;
    - wr_ptr would reach DEPTH;
    - mispredict.
  - Writing the instruction with in_pc==br_pc completes capture: go to REPLAY with rd_ptr=0 and loop_iters=0.
- REPLAY:
  - fetch_stall=1, loop_active=1, replay_valid=1.
  - replay_pc and replay_insn come from entry rd_ptr (combinational read), valid in the first REPLAY cycle.
  - On replay_valid&&replay_ready: rd_ptr+1, wrapping at len-1 to 0.
  - Each wrap increments loop_iters, saturating at all-ones.
  - With replay_ready=0, outputs hold stable.
  - in_valid is ignored.
- EXIT: entered when mispredict=1 in REPLAY.
  - A handshake in the same cycle still completes.
  - Next cycle: flush=1, redirect_pc=br_pc+4, fetch_stall=0, replay_valid=0.
  - Then go to IDLE.
- Outputs outside REPLAY/EXIT: replay_valid=0, fetch_stall=0, flush=0, loop_active=0. redirect_pc and loop_iters hold their last value.
- Reset, including mid-REPLAY: state=IDLE; all outputs 0; conf, wr_ptr, rd_ptr, loop_iters=0. Storage contents are not reset (don't-care).
- PC arithmetic is modulo 2^XLEN. Entry index width is $clog2(DEPTH).

Decomposition:
- Package loop_buffer_pkg holds:
  - opcode constants OPC_BRANCH, OPC_JAL;
  - state enum {IDLE, ARM, CAPTURE, REPLAY, EXIT};
  - function is_backward_ctrl(insn, imm, depth).
- Sub-module loop_buffer_ram: DEPTH x (XLEN+32) storage with one synchronous write port and one asynchronous read port.

Test Plan:
1. CONF_THRESH=2, loop 0x100..0x10C with BNE at 0x10C, imm=-12, three passes -> ARM after pass 1, CAPTURE on pass 2, REPLAY after pass 3 writes 0x10C; replay_pc sequence 0x100,0x104,0x108,0x10C,0x100; loop_iters=1 after the first wrap.
2. In REPLAY, hold replay_ready=0 for 5 cycles, then 1 -> replay_pc stable during the hold, advances one entry per ready cycle.
3. Raise mispredict in REPLAY with replay_ready=1 -> that handshake completes; next cycle flush=1 for exactly 1 cycle with redirect_pc=0x110; state returns to IDLE.
4. Inner BEQ at 0x104 during CAPTURE -> IDLE, no flush, fetch_stall never asserted.
5. Candidate with imm=-(4*DEPTH) -> ignored, state stays IDLE; imm=-(4*(DEPTH-1)) -> accepted.
6. Assert reset mid-REPLAY -> next cycle all outputs 0 and state IDLE; the same loop re-captures only after CONF_THRESH new sightings.
